reg_op_sequencer: RTL
=====================

# reg_op_sequencer

Multi-cycle operation sequencer that drives the 8 x 8-bit register file's single combinational read port and level-sensitive write port. It accepts one two-register instruction at a time over a valid/ready handshake and reads operands serially through the one read port. It computes the result, writes it back to the destination register with a one-cycle `reg_write` pulse, and updates zero/carry flags. The block sits between instruction decode and the register file in the processor datapath.

## Interface
- No parameters. Data width is 8 bits and register index width is 3 bits, both fixed.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the reset state immediately.
- `instr_valid` in 1: instruction fields are valid this cycle.
- `instr_ready` out 1: equals (state==IDLE) & ~reset.
- `opcode` in 2: 00 ADD, 01 SUB, 10 MOV, 11 AND.
- `rd` in 3: destination register, which is also operand A.
- `rs` in 3: source register, operand B.
- `read_reg_no` out 3: register file read index.
- `read_data` in 8: register file read data, combinational from `read_reg_no`.
- `write_reg_no` out 3: register file write index.
- `write_data` out 8: register file write data.
- `reg_write` out 1: register file write enable.
- `done` out 1: one-cycle pulse coincident with `reg_write`.
- `zero_flag` out 1: last result == 0.
- `carry_flag` out 1: ADD carry-out or SUB borrow from the last instruction.

## Operation
- States are IDLE, RD_B, RD_A, EXEC, WB.
- IDLE: on `instr_valid & instr_ready`, latch opcode/rd/rs and go to RD_B. Otherwise stay in IDLE. `read_reg_no` = 0.
- RD_B: `read_reg_no` = rs; capture `read_data` into opB at the clock edge. Next state is RD_A, or EXEC for MOV.
- RD_A: `read_reg_no` = rd; capture opA. Next state is EXEC.
- EXEC: compute with a 9-bit internal sum, register the result and update the flags. `read_reg_no` = 0. Next state is WB.
  - ADD: {c,r} = opA+opB; carry = c.
  - SUB: r = opA-opB mod 256; carry = (opB > opA).
  - MOV: r = opB; carry = 0.
  - AND: r = opA & opB; carry = 0.
  - All opcodes: zero = (r == 0).
- WB: `reg_write` = 1, `write_reg_no` = latched rd, `write_data` = result, `done` = 1. Next state is IDLE.
- Write hold: `write_reg_no` and `write_data` are registered. They are stable for the whole WB cycle and hold their last values afterwards, because the register file write is level-sensitive.
- `reg_write` is decoded from the state register only, so it is glitch-free and never high outside WB.
- rd == rs is legal: both reads return the same value. Example: ADD r3,r3 with R3=3 writes 6.
- Instruction inputs are ignored outside IDLE.
- Reset values: state IDLE, `reg_write` 0, `done` 0, `read_reg_no` 0, `write_reg_no` 0, `write_data` 0, `zero_flag` 0, `carry_flag` 0, `instr_ready` 0 while reset is high.
- Reset mid-operation: the instruction is abandoned, no write occurs (`reg_write` drops asynchronously), and flags are cleared.

## Timing
- Let cycle 0 be the accept edge.
- ADD/SUB/AND: RD_B in cycle 1, RD_A in cycle 2, EXEC in cycle 3, WB in cycle 4. Write latency is 4 cycles.
- MOV: RD_B in cycle 1, EXEC in cycle 2, WB in cycle 3. Write latency is 3 cycles.
- `instr_ready` is low from cycle 1 through the WB cycle inclusive. It rises in the cycle after WB, so the earliest next accept is cycle 5 (cycle 4 after a MOV).
- Throughput is one instruction per 5 cycles (4 for MOV).
- Flags become visible in the WB cycle and hold until the next EXEC or reset.
- `read_data` is sampled at the end of the RD_B and RD_A cycles. A write completed in WB is visible to the next instruction's reads.

## Test plan
- Reset, then ADD rd=2 rs=5 (R2=2, R5=5) -> in cycle 4, `reg_write`=1, `write_reg_no`=2, `write_data`=0x07, `done`=1; zero=0, carry=0.
- SUB rd=3 rs=4 (R3=3, R4=4) -> writes 0xFF to R3; carry=1, zero=0.
- Following ADD rd=3 rs=1 (R3=0xFF, R1=1) -> writes 0x00 to R3; carry=1, zero=1.
- MOV rd=0 rs=7 -> `reg_write` in cycle 3 with `write_data`=0x07 to R0; `read_reg_no` is 7 in cycle 1; `instr_ready` is low in cycles 1-3.
- `instr_valid` held high with two queued AND rd=6 rs=7 instructions -> second accept in cycle 5; first writes 6&7=0x06; `reg_write` high exactly one cycle per instruction.
- Assert `reset` asynchronously during EXEC of an ADD -> `reg_write` never asserts, flags read 0, and `instr_ready` rises in the first cycle after reset deasserts.

Source files
------------

// File: rtl/reg_op_sequencer_if.sv
// Bundle of the instruction handshake and register-file port signals
// between decode/register file (master side) and the operation sequencer
// (slave side).
interface reg_op_sequencer_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [1:0] opcode;
   logic [2:0] rd;
   logic [2:0] rs;
   logic [2:0] read_reg_no;
   logic [7:0] read_data;
   logic [2:0] write_reg_no;
   logic [7:0] write_data;
   logic       reg_write;
   logic       done;
   logic       zero_flag;
   logic       carry_flag;

   modport master (
      output instr_valid, opcode, rd, rs, read_data,
      input  instr_ready, read_reg_no, write_reg_no, write_data,
             reg_write, done, zero_flag, carry_flag
   );

   modport slave (
      input  instr_valid, opcode, rd, rs, read_data,
      output instr_ready, read_reg_no, write_reg_no, write_data,
             reg_write, done, zero_flag, carry_flag
   );
endinterface

// File: rtl/reg_op_sequencer.sv
// Multi-cycle two-register operation sequencer. Reads operand B (rs) and
// operand A (rd) serially through the register file's single read port,
// computes ADD/SUB/MOV/AND, writes the result back to rd with a one-cycle
// reg_write pulse and keeps zero/carry flags of the last result.
module reg_op_sequencer (
   input  logic                      clk,
   input  logic                      reset,
   reg_op_sequencer_if.slave         bus
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD_B = 3'd1;
   localparam logic [2:0] RD_A = 3'd2;
   localparam logic [2:0] EXEC = 3'd3;
   localparam logic [2:0] WB   = 3'd4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MOV = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [1:0] op_lat;
   logic [2:0] rd_lat;
   logic [2:0] rs_lat;
   logic [7:0] opa;
   logic [7:0] opb;
   logic [8:0] sum9;
   logic [7:0] result;
   logic       carry_res;
   logic [2:0] wr_no;
   logic [7:0] wr_data;
   logic       zero;
   logic       carry;
   logic [2:0] rd_port;

   // Next-state selection; MOV skips the operand A read.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.instr_valid) begin
               state_nxt = RD_B;
            end else begin
               state_nxt = IDLE;
            end
         end
         RD_B: begin
            if (op_lat == OP_MOV) begin
               state_nxt = EXEC;
            end else begin
               state_nxt = RD_A;
            end
         end
         RD_A:    state_nxt = EXEC;
         EXEC:    state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read-port index: rs during RD_B, rd during RD_A, otherwise register 0.
   always_comb begin
      rd_port = 3'd0;
      case (state)
         RD_B:    rd_port = rs_lat;
         RD_A:    rd_port = rd_lat;
         default: rd_port = 3'd0;
      endcase
   end

   // ALU: 9-bit sum gives ADD carry-out and SUB borrow (opB > opA) in bit 8.
   always_comb begin
      sum9      = 9'd0;
      result    = 8'd0;
      carry_res = 1'b0;
      case (op_lat)
         OP_ADD: begin
            sum9      = {1'b0, opa} + {1'b0, opb};
            result    = sum9[7:0];
            carry_res = sum9[8];
         end
         OP_SUB: begin
            sum9      = {1'b0, opa} - {1'b0, opb};
            result    = sum9[7:0];
            carry_res = sum9[8];
         end
         OP_MOV: begin
            result    = opb;
            carry_res = 1'b0;
         end
         OP_AND: begin
            result    = opa & opb;
            carry_res = 1'b0;
         end
         default: begin
            result    = 8'd0;
            carry_res = 1'b0;
         end
      endcase
   end

   // State register; reset abandons any in-flight instruction immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the instruction fields on the accept edge only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_lat <= 2'b00;
         rd_lat <= 3'd0;
         rs_lat <= 3'd0;
      end else if ((state == IDLE) && bus.instr_valid) begin
         op_lat <= bus.opcode;
         rd_lat <= bus.rd;
         rs_lat <= bus.rs;
      end
   end

   // Capture operands from the combinational read port at the end of each read state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opa <= 8'd0;
         opb <= 8'd0;
      end else if (state == RD_B) begin
         opb <= bus.read_data;
      end else if (state == RD_A) begin
         opa <= bus.read_data;
      end
   end

   // Register result, write address and flags at the end of EXEC; they hold
   // afterwards so the level-sensitive write port sees stable values in WB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_no   <= 3'd0;
         wr_data <= 8'd0;
         zero    <= 1'b0;
         carry   <= 1'b0;
      end else if (state == EXEC) begin
         wr_no   <= rd_lat;
         wr_data <= result;
         zero    <= (result == 8'd0);
         carry   <= carry_res;
      end
   end

   assign bus.instr_ready  = (state == IDLE) & ~reset;
   assign bus.read_reg_no  = rd_port;
   assign bus.write_reg_no = wr_no;
   assign bus.write_data   = wr_data;
   assign bus.reg_write    = (state == WB);
   assign bus.done         = (state == WB);
   assign bus.zero_flag    = zero;
   assign bus.carry_flag   = carry;

endmodule
